// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared constants, tx state enum and byte-select helper for the iot blocks
package iot_pkg;

  localparam int BYTES_PER_WORD          = 16;
  localparam int DEFAULT_WORDS_PER_FRAME = 8;
  localparam int WORD_W                  = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Byte k of a word, MSB first: k=0 is bits [127:120].
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [3:0] k);
    logic [WORD_W-1:0] s;
    s = w << (8 * k);
    return s[WORD_W-1 -: 8];
  endfunction

endpackage

// File: rtl/iot_tx_if.sv
// rtl/iot_tx_if.sv - word write port, busy back-pressure and serialized byte stream
interface iot_tx_if;
  import iot_pkg::*;

  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              busy;
  logic              in_en;
  logic [7:0]        iot_in;
  logic [3:0]        byte_idx;
  logic [2:0]        word_idx;
  logic              frame_done;

  modport master (
    output wr_valid, wr_data, busy,
    input  wr_ready, in_en, iot_in, byte_idx, word_idx, frame_done
  );

  modport slave (
    input  wr_valid, wr_data, busy,
    output wr_ready, in_en, iot_in, byte_idx, word_idx, frame_done
  );

endinterface

// File: rtl/iot_tx_fifo.sv
// rtl/iot_tx_fifo.sv - power-of-two word FIFO with registered full/empty flags
module iot_tx_fifo
  import iot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + 1'b1;
    else if (do_pop && !do_push)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iot_tx.sv
// rtl/iot_tx.sv - serializes queued 128-bit words into MSB-first bytes with word/frame tracking
module iot_tx
  import iot_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME
) (
  input  logic   clk,
  input  logic   rst,
  iot_tx_if.slave bus
);

  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_FRAME - 1);

  tx_state_e         state, state_n;
  logic [3:0]        byte_q, byte_n;
  logic [2:0]        word_q, word_n;
  logic              in_en_q, in_en_n;
  logic [7:0]        iot_in_q, iot_in_n;
  logic              fd_q, fd_n;
  logic              ready_en;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] head;

  // ready_en holds wr_ready low until the first edge after reset release.
  assign bus.wr_ready   = ready_en && !fifo_full;
  assign push           = bus.wr_valid && bus.wr_ready;
  assign bus.in_en      = in_en_q;
  assign bus.iot_in     = iot_in_q;
  assign bus.byte_idx   = byte_q;
  assign bus.word_idx   = word_q;
  assign bus.frame_done = fd_q;

  iot_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.wr_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Busy is only sampled in IDLE; once a word starts it always runs 16 bytes.
  always_comb begin
    state_n  = state;
    byte_n   = '0;
    word_n   = word_q;
    in_en_n  = 1'b0;
    iot_in_n = '0;
    fd_n     = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.busy) begin
          state_n  = SEND;
          in_en_n  = 1'b1;
          iot_in_n = word_byte(head, 4'd0);
        end
      end
      SEND: begin
        if (byte_q == 4'(BYTES_PER_WORD - 1)) begin
          pop     = 1'b1;
          state_n = IDLE;
          word_n  = (word_q == LAST_WORD) ? 3'd0 : word_q + 3'd1;
        end else begin
          byte_n   = byte_q + 4'd1;
          in_en_n  = 1'b1;
          iot_in_n = word_byte(head, byte_n);
          fd_n     = (byte_n == 4'(BYTES_PER_WORD - 1)) && (word_q == LAST_WORD);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_q   <= '0;
      word_q   <= '0;
      in_en_q  <= 1'b0;
      iot_in_q <= '0;
      fd_q     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      byte_q   <= byte_n;
      word_q   <= word_n;
      in_en_q  <= in_en_n;
      iot_in_q <= iot_in_n;
      fd_q     <= fd_n;
      ready_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iot_tx.sv
// tb/tb_iot_tx.sv - scoreboard bench for iot_tx: ordering, latency, stalls, full FIFO, reset
module tb_iot_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_tx_if bus ();

  iot_tx #(
    .DEPTH           (4),
    .WORDS_PER_FRAME (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic [3:0] bi;
    logic [2:0] wi;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   exp_wi   = 0;

  task automatic push_word(input logic [127:0] d);
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      e.b  = d[127-8*k -: 8];
      e.bi = 4'(k);
      e.wi = 3'(exp_wi);
      e.fd = (k == 15) && (exp_wi == 7);
      sb.push_back(e);
    end
    exp_wi = (exp_wi + 1) % 8;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_en === 1'b1) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_byte got iot_in=%h byte_idx=%0d required no in_en", bus.iot_in, bus.byte_idx);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.iot_in, bus.byte_idx, bus.word_idx, bus.frame_done} !== {mon_e.b, mon_e.bi, mon_e.wi, mon_e.fd})
            $display("FAIL sb_byte got %h/%0d/%0d/%b required %h/%0d/%0d/%b (iot_in/byte/word/done)",
                     bus.iot_in, bus.byte_idx, bus.word_idx, bus.frame_done, mon_e.b, mon_e.bi, mon_e.wi, mon_e.fd);
          else
            pass_cnt++;
        end
      end else begin
        chk_cnt++;
        if (bus.iot_in !== 8'h00 || bus.byte_idx !== 4'd0 || bus.frame_done !== 1'b0 || bus.in_en !== 1'b0)
          $display("FAIL idle_zero got in_en=%b iot_in=%h byte_idx=%0d done=%b required 0/00/0/0",
                   bus.in_en, bus.iot_in, bus.byte_idx, bus.frame_done);
        else
          pass_cnt++;
      end
    end
  end

  task automatic apply_reset();
    bus.wr_valid = 1'b0;
    bus.busy     = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_wi = 0;
  endtask

  task automatic write_word(input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.wr_ready !== 1'b1 && n < 300) begin
      bus.wr_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk_cnt++;
      $display("FAIL write_timeout got wr_ready=%b required 1", bus.wr_ready);
    end else begin
      bus.wr_data  = d;
      bus.wr_valid = 1'b1;
      @(posedge clk);
      push_word(d);
    end
  endtask

  task automatic end_write();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.in_en === 1'b1) && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL %s_drain got %0d bytes pending required 0", name, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if ({bus.wr_ready, bus.in_en, bus.iot_in, bus.byte_idx, bus.word_idx, bus.frame_done} !== 17'd0)
      $display("FAIL reset_outputs got ready=%b in_en=%b iot_in=%h byte=%0d word=%0d done=%b required all 0",
               bus.wr_ready, bus.in_en, bus.iot_in, bus.byte_idx, bus.word_idx, bus.frame_done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (bus.wr_ready !== 1'b1) $display("FAIL reset_ready_after got %b required 1", bus.wr_ready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int run;
    apply_reset();
    write_word(128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk_cnt++;
    if (bus.in_en !== 1'b0) $display("FAIL single_no_bypass got in_en=%b required 0", bus.in_en);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_en !== 1'b1 || bus.iot_in !== 8'h00 || bus.byte_idx !== 4'd0)
      $display("FAIL single_latency got in_en=%b iot_in=%h required 1/00", bus.in_en, bus.iot_in);
    else pass_cnt++;
    run = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.in_en !== 1'b1) break;
      run++;
    end
    chk_cnt++;
    if (run != 16) $display("FAIL single_len got %0d required 16", run);
    else pass_cnt++;
    drain("single");
  endtask

  task automatic test_frame();
    logic [127:0] words [8];
    int run, gap, nwords, fdc;
    bit started;
    apply_reset();
    for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    run = 0; gap = 0; nwords = 0; fdc = 0; started = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) write_word(words[i]);
        end_write();
      end
      begin
        for (int c = 0; c < 500 && nwords < 8; c++) begin
          @(negedge clk);
          if (bus.in_en === 1'b1) begin
            if (started && run == 0) begin
              chk_cnt++;
              if (gap != 1) $display("FAIL frame_gap got %0d required 1", gap);
              else pass_cnt++;
            end
            started = 1;
            run++;
            gap = 0;
            if (bus.frame_done === 1'b1) fdc++;
          end else if (run > 0) begin
            chk_cnt++;
            if (run != 16) $display("FAIL frame_len got %0d required 16", run);
            else pass_cnt++;
            nwords++;
            run = 0;
            gap = 1;
          end else if (started) begin
            gap++;
          end
        end
      end
    join
    chk_cnt++;
    if (nwords != 8) $display("FAIL frame_words got %0d required 8", nwords);
    else pass_cnt++;
    chk_cnt++;
    if (fdc != 1) $display("FAIL frame_done_count got %0d required 1", fdc);
    else pass_cnt++;
    chk_cnt++;
    if (bus.word_idx !== 3'd0) $display("FAIL frame_wrap got %0d required 0", bus.word_idx);
    else pass_cnt++;
    drain("frame");
  endtask

  task automatic test_busy();
    int seen, cnt, n;
    logic [3:0] last;
    apply_reset();
    bus.busy = 1'b1;
    write_word({4{32'hA5A5_0001}});
    write_word({4{32'h5A5A_0002}});
    end_write();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_en === 1'b1) seen++;
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL busy_hold got %0d in_en cycles required 0", seen);
    else pass_cnt++;
    bus.busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (bus.in_en !== 1'b1 || bus.byte_idx !== 4'd0)
      $display("FAIL busy_release got in_en=%b byte=%0d required 1/0", bus.in_en, bus.byte_idx);
    else pass_cnt++;
    n = 0;
    while (bus.byte_idx !== 4'd5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.busy = 1'b1;
    cnt = 1;
    last = bus.byte_idx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.in_en !== 1'b1) break;
      last = bus.byte_idx;
      cnt++;
    end
    chk_cnt++;
    if (cnt != 11 || last !== 4'd15) $display("FAIL busy_midword got %0d bytes last=%0d required 11/15", cnt, last);
    else pass_cnt++;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.in_en === 1'b1) seen++;
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL busy_second_hold got %0d required 0", seen);
    else pass_cnt++;
    bus.busy = 1'b0;
    drain("busy");
  endtask

  task automatic test_full();
    apply_reset();
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) write_word({$urandom, $urandom, $urandom, 32'(i)});
    end_write();
    chk_cnt++;
    if (bus.wr_ready !== 1'b0) $display("FAIL full_ready got %b required 0", bus.wr_ready);
    else pass_cnt++;
    bus.wr_data  = {4{32'hDEAD_BEEF}};
    bus.wr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.wr_ready !== 1'b0) $display("FAIL full_fifth got wr_ready=%b required 0", bus.wr_ready);
      else pass_cnt++;
    end
    bus.wr_valid = 1'b0;
    bus.busy     = 1'b0;
    drain("full");
    chk_cnt++;
    if (bus.wr_ready !== 1'b1) $display("FAIL full_ready_after got %b required 1", bus.wr_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, seen;
    apply_reset();
    for (int i = 0; i < 4; i++) write_word({32'(i), $urandom, $urandom, $urandom});
    end_write();
    n = 0;
    while (!(bus.in_en === 1'b1 && bus.byte_idx === 4'd7 && bus.word_idx === 3'd0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n >= 60) $display("FAIL rstmid_reach got byte=%0d required 7", bus.byte_idx);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.wr_ready, bus.in_en, bus.iot_in, bus.byte_idx, bus.word_idx, bus.frame_done} !== 17'd0)
      $display("FAIL rstmid_outputs got in_en=%b iot_in=%h byte=%0d required 0", bus.in_en, bus.iot_in, bus.byte_idx);
    else pass_cnt++;
    sb.delete();
    exp_wi = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.in_en === 1'b1) seen++;
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL rstmid_resume got %0d in_en cycles required 0", seen);
    else pass_cnt++;
    write_word(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978);
    end_write();
    drain("rstmid");
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.busy     = 1'b0;
    test_reset();
    test_single();
    test_frame();
    test_busy();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iot_tx.md
IOT_TX -- requirements
Module: iot_tx

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the input word FIFO depth in 128-bit entries; legal values are powers of two, 2 or more.
REQ-002 Parameter WORDS_PER_FRAME, default 8, SHALL set the number of words per frame.
REQ-003 clk  input  1  clock; all state SHALL be updated on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  upstream word valid.
REQ-006 wr_data  input  128  upstream word.
REQ-007 wr_ready  output  1  FIFO can accept a word.
REQ-008 busy  input  1  downstream filter is busy; no new word may start while it is high.
REQ-009 in_en  output  1  iot_in carries a valid byte this cycle.
REQ-010 iot_in  output  8  serialized byte.
REQ-011 byte_idx  output  4  index of the current byte within its word (0..15).
REQ-012 word_idx  output  3  index of the current word within its frame (0..WORDS_PER_FRAME-1).
REQ-013 frame_done  output  1  one-cycle pulse coinciding with the last byte of the last word of a frame.

Function
REQ-014 A write SHALL occur on any edge where wr_valid and wr_ready are both 1.
REQ-015 wr_ready SHALL equal not-full, registered from FIFO occupancy.
- When full, a write SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-016 The FSM SHALL have two states, IDLE and SEND; the reset state is IDLE.
REQ-017 IDLE to SEND transition SHALL occur when the FIFO is non-empty and busy is 0; otherwise the FSM stays in IDLE.
REQ-018 In SEND, in_en SHALL be 1 for exactly 16 consecutive cycles, and busy SHALL be ignored mid-word.
REQ-019 Byte order SHALL be MSB first: byte k = head[127-8k -: 8]; byte_idx SHALL equal k.
REQ-020 On the edge ending byte 15, the FIFO head SHALL be popped and the FSM SHALL return to IDLE.
- This guarantees a minimum one-cycle in_en=0 gap between words.
REQ-021 Latency: a word written on edge t into an empty FIFO, with the FSM in IDLE and busy=0, SHALL have its byte 0 presented in the cycle after edge t+1.
REQ-022 When in_en=0, iot_in and byte_idx SHALL be 0.
REQ-023 word_idx SHALL increment on each pop and wrap from WORDS_PER_FRAME-1 to 0.
REQ-024 frame_done SHALL be 1 only when in_en=1, byte_idx=15 and word_idx=WORDS_PER_FRAME-1.
REQ-025 A simultaneous write and pop SHALL leave the occupancy unchanged, and both operations SHALL take effect.
REQ-026 A write into an empty FIFO SHALL NOT bypass the FIFO; the word is visible to the FSM one cycle later.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-028 While rst=1, the following SHALL hold immediately and asynchronously:
- FSM=IDLE, FIFO empty;
- wr_ready=0 during reset and 1 from the first edge after release;
- in_en=0, iot_in=0, byte_idx=0, word_idx=0, frame_done=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word and all queued words; no bytes SHALL be resumed after release.

Structure
REQ-030 A shared package iot_pkg SHALL hold the following, shared with the filter blocks:
- BYTES_PER_WORD=16;
- default WORDS_PER_FRAME=8;
- the tx state enum (IDLE, SEND).
REQ-031 The FIFO SHALL be a separate sub-module, iot_tx_fifo, with:
- push/pop/full/empty ports;
- parameters DEPTH and width 128;
- pointer wrap modulo DEPTH.
REQ-032 The FSM, byte/word counters and byte mux SHALL reside in iot_tx.

Verification
REQ-033 Single word: write 0x00112233_44556677_8899AABB_CCDDEEFF with busy=0 -> 16 in_en cycles with iot_in 0x00,0x11,...,0xFF; byte_idx 0..15; word_idx=0.
REQ-034 Frame: 8 words back-to-back, busy=0 -> each word followed by exactly one idle cycle; word_idx 0..7 then wraps to 0; frame_done pulses once, on byte 15 of word 7.
REQ-035 Busy stall, case 1: hold busy=1 with 2 words queued -> in_en stays 0.
REQ-036 Busy stall, case 2: drop busy at cycle c -> byte 0 in the cycle after edge c.
REQ-037 Busy stall, case 3: raise busy during byte 5 -> the word still completes all 16 bytes.
REQ-038 Full FIFO: with busy=1, write 4 words -> wr_ready=0; a 5th wr_valid is not accepted; release busy -> exactly 4 words are sent in order.
REQ-039 Reset mid-word: assert rst during byte 7 of word 0 with 3 words queued -> outputs zero immediately; after release, no in_en until a new write occurs.
